// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared types and helpers for the bit-serial adder controller:
//               FSM state encoding, default operand width and counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    // Controller states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operand/sum width used when the instantiating level does not override it
    localparam int DEFAULT_WIDTH = 8;

    // Bit counter width: enough to count 0..width-1, never narrower than 1 bit
    function automatic int cnt_width(input int width);
        if ($clog2(width) < 1) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/half_adder_cell.sv
`default_nettype none
// ============================================================================
// Module      : half_adder_cell
// Description : Combinational one-bit half adder. Two of these plus an OR of
//               their carries form the full-add slice of the serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule : half_adder_cell
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial adder. Accepts two WIDTH-bit operands over a
//               valid/ready handshake, adds them LSB first one bit per clock
//               through a shared full-add slice, and presents sum and carry
//               over a second valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C
);

    localparam int             C_CNT_W = cnt_width(WIDTH);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_a_sh;
    logic [WIDTH-1:0]     r_b_sh;
    logic [WIDTH-1:0]     r_sum_sh;
    logic [WIDTH-1:0]     w_sum_next;
    logic                 r_carry;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 w_last;

    // Full-add slice signals
    logic w_p;
    logic w_g1;
    logic w_s;
    logic w_g2;
    logic w_carry_next;

    // The LSB of the sum register is shifted out on the final bit and never read
    logic w_unused_sum_lsb;
    assign w_unused_sum_lsb = r_sum_sh[0];

    // First cell: propagate and generate of the operand bits
    half_adder_cell u_ha_operands (
        .a (r_a_sh[0]),
        .b (r_b_sh[0]),
        .s (w_p),
        .c (w_g1)
    );

    // Second cell: fold in the running carry
    half_adder_cell u_ha_carry (
        .a (w_p),
        .b (r_carry),
        .s (w_s),
        .c (w_g2)
    );

    assign w_carry_next = w_g1 | w_g2;
    assign w_last       = (r_cnt == C_LAST);

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB
    generate
        if (WIDTH > 1) begin : g_sum_wide
            assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:1]};
        end else begin : g_sum_single
            assign w_sum_next = w_s;
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs decoded from the registered state
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand load, per-bit shift/accumulate, result capture on last bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            S        <= '0;
            C        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sh   <= A;
                        r_b_sh   <= B;
                        r_sum_sh <= '0;
                        r_carry  <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_sum_sh <= w_sum_next;
                    r_carry  <= w_carry_next;
                    if (w_last) begin
                        // Result registers only change here, so they hold
                        // steady through DONE and the next operation's RUN
                        S <= w_sum_next;
                        C <= w_carry_next;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : serial_adder_ctrl
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Directed self-checking bench for serial_adder_ctrl, covering
//               an 8-bit instance and a 1-bit instance on a shared clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    // 8-bit instance
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] s;
    logic       c;

    // 1-bit instance
    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] s1;
    logic       c1;

    int errors   = 0;
    int checks   = 0;
    int accepted = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (s),
        .C         (c)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .A         (a1),
        .B         (b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .S         (s1),
        .C         (c1)
    );

    // Count operand handshakes on the 8-bit instance
    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) begin
            accepted <= accepted + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands once in_ready is seen; returns just after the accept edge
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        check("in_ready_wait", {31'b0, in_ready}, 32'd1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Edges elapsed until out_valid rises (bounded)
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] exp_s, input logic exp_c);
        int lat;
        start_op(av, bv);
        wait_done(lat);
        check({tag, "_latency"}, lat, 32'd8);
        check({tag, "_S"}, {24'b0, s}, {24'b0, exp_s});
        check({tag, "_C"}, {31'b0, c}, {31'b0, exp_c});
        tick();
        check({tag, "_in_ready_back"}, {31'b0, in_ready}, 32'd1);
        check({tag, "_out_valid_drop"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int       lat;
        int       base;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [8:0] sum;

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a          = 8'h00;
        b          = 8'h00;
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        a1         = 1'b0;
        b1         = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_S", {24'b0, s}, 32'd0);
        check("rst_C", {31'b0, c}, 32'd0);

        // 0x5A + 0x3C, including idle-of-result view during RUN
        start_op(8'h5A, 8'h3C);
        check("run1_in_ready", {31'b0, in_ready}, 32'd0);
        check("run1_S_prev", {24'b0, s}, 32'd0);
        wait_done(lat);
        check("op1_latency", lat, 32'd8);
        check("op1_S", {24'b0, s}, 32'h96);
        check("op1_C", {31'b0, c}, 32'd0);
        tick();
        check("op1_in_ready_back", {31'b0, in_ready}, 32'd1);

        // Carry-out, then carry cleared for the next operation
        run_op("ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
        start_op(8'h00, 8'h00);
        check("run_C_prev", {31'b0, c}, 32'd1);
        wait_done(lat);
        check("zero_latency", lat, 32'd8);
        check("zero_S", {24'b0, s}, 32'h00);
        check("zero_C", {31'b0, c}, 32'd0);
        tick();

        // Backpressure in DONE
        out_ready = 1'b0;
        start_op(8'h80, 8'h80);
        wait_done(lat);
        check("bp_latency", lat, 32'd8);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_S", {24'b0, s}, 32'h00);
            check("bp_C", {31'b0, c}, 32'd1);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        check("bp_release_out_valid", {31'b0, out_valid}, 32'd0);

        // in_valid during RUN is ignored
        base = accepted;
        start_op(8'h11, 8'h22);
        tick();
        tick();
        a        = 8'hFF;
        b        = 8'hFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done(lat);
        check("ign_latency", lat, 32'd5);
        check("ign_S", {24'b0, s}, 32'h33);
        check("ign_C", {31'b0, c}, 32'd0);
        tick();
        check("ign_accepted", accepted - base, 32'd1);

        // Reset during the 4th RUN cycle aborts the operation
        start_op(8'hF0, 8'h0F);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_S", {24'b0, s}, 32'd0);
        check("abort_C", {31'b0, c}, 32'd0);
        tick();
        check("abort_stays_idle", {31'b0, out_valid}, 32'd0);
        run_op("after_abort", 8'h12, 8'h34, 8'h46, 1'b0);

        // Random operands against A+B
        for (int i = 0; i < 16; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            sum = {1'b0, ra} + {1'b0, rb};
            run_op("rand", ra, rb, sum[7:0], sum[8]);
        end

        // 1-bit instance: 1+1 then 1+0
        a1        = 1'b1;
        b1        = 1'b1;
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        check("w1_run_out_valid", {31'b0, out_valid1}, 32'd0);
        tick();
        check("w1_out_valid", {31'b0, out_valid1}, 32'd1);
        check("w1_S", {31'b0, s1}, 32'd0);
        check("w1_C", {31'b0, c1}, 32'd1);
        tick();
        check("w1_in_ready_back", {31'b0, in_ready1}, 32'd1);
        a1        = 1'b1;
        b1        = 1'b0;
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        tick();
        check("w1b_out_valid", {31'b0, out_valid1}, 32'd1);
        check("w1b_S", {31'b0, s1}, 32'd1);
        check("w1b_C", {31'b0, c1}, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
`default_nettype wire
